// File: rtl/cordic_flow_ctrl.sv
// cordic_flow_ctrl: valid/ready wrapper around a fixed-latency, non-stallable
// cosine pipeline. Angles are issued only when the output FIFO is guaranteed
// to have room for the result, so captured results are never dropped.
// Issue-to-capture timing: an angle accepted at edge T sets vld_sr[0] after T
// and reaches vld_sr[LATENCY-1] after edge T+LATENCY-1, which is the cycle in
// which the cosine presents its result. The FIFO stores that result on the
// following edge, and m_valid rises in the cycle after that store.
module cordic_flow_ctrl #(
  parameter int LATENCY = 4,
  parameter int DEPTH   = 8,
  parameter int DATA_W  = 32
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           flush,
  input  logic                           s_valid,
  output logic                           s_ready,
  input  logic [DATA_W-1:0]              s_angle,
  output logic [DATA_W-1:0]              cos_angle,
  output logic                           cos_clk_en,
  output logic                           cos_reset,
  input  logic [DATA_W-1:0]              cos_result,
  output logic                           m_valid,
  input  logic                           m_ready,
  output logic [DATA_W-1:0]              m_result,
  output logic [$clog2(LATENCY+1)-1:0]   inflight
);

  localparam int ADDR = $clog2(DEPTH);
  localparam int IFW  = $clog2(LATENCY+1);
  localparam int CW   = ADDR + 1;

  logic [LATENCY-1:0] vld_sr_q, vld_sr_d;
  logic [ADDR-1:0]    wr_ptr_q, wr_ptr_d;
  logic [ADDR-1:0]    rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]      count_q, count_d;
  logic [DATA_W-1:0]  mem_q [DEPTH];
  logic [DATA_W-1:0]  mem_d [DEPTH];

  logic [IFW-1:0]     inflight_c;
  logic [CW:0]        used_c;
  logic               accept;
  logic               wr_en;
  logic               rd_en;

  // The cosine sees the angle directly; it runs whenever reset is released
  // and its stages are wiped by the same flush that empties the FIFO.
  assign cos_angle  = s_angle;
  assign cos_clk_en = reset;
  assign cos_reset  = flush;

  // Count issued angles whose results have not yet been written to the FIFO.
  always_comb begin
    inflight_c = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight_c = inflight_c + IFW'(vld_sr_q[i]);
    end
  end

  // Credit check uses registered terms only, so a same-cycle pop never opens
  // the input and there is no combinational path from m_ready to s_ready.
  always_comb begin
    used_c   = {1'b0, count_q} + (CW+1)'(inflight_c);
    s_ready  = reset & ~flush & (used_c < (CW+1)'(DEPTH));
    m_valid  = (count_q != '0);
    m_result = mem_q[rd_ptr_q];
    inflight = inflight_c;
    accept   = s_valid & s_ready;
    wr_en    = vld_sr_q[LATENCY-1];
    rd_en    = m_valid & m_ready;
  end

  // Next-state for the valid tracker and FIFO; flush discards everything.
  always_comb begin
    vld_sr_d = {vld_sr_q[LATENCY-2:0], accept};
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      vld_sr_d = '0;
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (wr_en) begin
        mem_d[wr_ptr_q] = cos_result;
        wr_ptr_d        = wr_ptr_q + ADDR'(1);
      end
      if (rd_en) begin
        rd_ptr_d = rd_ptr_q + ADDR'(1);
      end
      case ({wr_en, rd_en})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  // State registers, cleared immediately when reset goes low.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      vld_sr_q <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      vld_sr_q <= vld_sr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      mem_q    <= mem_d;
    end
  end

endmodule
